dmem_port_arbiter: RTL

//  Shares the single data-memory access port between the CPU load/store unit and the

---
 rtl/dmem_port_arbiter_pkg.sv | 20 ++
 rtl/dmem_port_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: bus width defaults, FSM states
// and requester IDs.
package dmem_port_arbiter_pkg;

  localparam int unsigned DMEM_ADDR_W = 10;
  localparam int unsigned DMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ACCESS  = 2'd1,
    ARB_CAPTURE = 2'd2,
    ARB_ACK     = 2'd3
  } arb_state_t;

  typedef enum logic {
    ARB_CPU = 1'b0,
    ARB_DBG = 1'b1
  } arb_id_t;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Shares one synchronous 1-cycle-read data-memory port between the CPU and the debugger.
// Optional DMEM_ARB_RR_EN: round-robin tie-break while the CPU runs (default: CPU priority).
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W,
  parameter int unsigned DATA_W = DMEM_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_cpu_address,
  input  logic [DATA_W-1:0] i_cpu_data,
  input  logic              i_cpu_read,
  input  logic              i_cpu_write,
  output logic [DATA_W-1:0] o_cpu_data,
  output logic              o_cpu_ack,
  input  logic [ADDR_W-1:0] i_dbg_address,
  input  logic [DATA_W-1:0] i_dbg_data,
  input  logic              i_dbg_read,
  input  logic              i_dbg_write,
  output logic [DATA_W-1:0] o_dbg_data,
  output logic              o_dbg_ack,
  input  logic              i_cpu_halt,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [DATA_W-1:0] o_mem_data,
  output logic              o_mem_read,
  output logic              o_mem_write,
  input  logic [DATA_W-1:0] i_mem_data
);

  arb_state_t state;
  arb_id_t    owner;
  arb_id_t    pick;
  logic       is_read;
  logic       cpu_req;
  logic       dbg_req;

  assign cpu_req = i_cpu_read | i_cpu_write;
  assign dbg_req = i_dbg_read | i_dbg_write;

`ifdef DMEM_ARB_RR_EN
  arb_id_t last_win;
`endif

  // Debugger wins when alone or while the CPU is halted; otherwise CPU unless RR says not.
  always_comb begin
    pick = ARB_CPU;
    if (dbg_req && (!cpu_req || i_cpu_halt)) pick = ARB_DBG;
`ifdef DMEM_ARB_RR_EN
    else if (dbg_req && last_win == ARB_CPU) pick = ARB_DBG;
`endif
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= ARB_IDLE;
      owner         <= ARB_CPU;
      is_read       <= 1'b0;
      o_mem_address <= '0;
      o_mem_data    <= '0;
      o_mem_read    <= 1'b0;
      o_mem_write   <= 1'b0;
      o_cpu_data    <= '0;
      o_cpu_ack     <= 1'b0;
      o_dbg_data    <= '0;
      o_dbg_ack     <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_win      <= ARB_DBG;
`endif
    end else begin
      o_cpu_ack <= 1'b0;
      o_dbg_ack <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (cpu_req || dbg_req) begin
            owner <= pick;
            state <= ARB_ACCESS;
`ifdef DMEM_ARB_RR_EN
            last_win <= pick;
`endif
            // Read+write together from one requester resolves to a write.
            if (pick == ARB_DBG) begin
              o_mem_address <= i_dbg_address;
              o_mem_data    <= i_dbg_data;
              o_mem_write   <= i_dbg_write;
              o_mem_read    <= ~i_dbg_write;
              is_read       <= ~i_dbg_write;
            end else begin
              o_mem_address <= i_cpu_address;
              o_mem_data    <= i_cpu_data;
              o_mem_write   <= i_cpu_write;
              o_mem_read    <= ~i_cpu_write;
              is_read       <= ~i_cpu_write;
            end
          end
        end
        ARB_ACCESS: begin
          o_mem_address <= '0;
          o_mem_data    <= '0;
          o_mem_read    <= 1'b0;
          o_mem_write   <= 1'b0;
          state         <= ARB_CAPTURE;
        end
        ARB_CAPTURE: begin
          if (is_read) begin
            if (owner == ARB_DBG) o_dbg_data <= i_mem_data;
            else                  o_cpu_data <= i_mem_data;
          end
          o_cpu_ack <= (owner == ARB_CPU);
          o_dbg_ack <= (owner == ARB_DBG);
          state     <= ARB_ACK;
        end
        ARB_ACK: state <= ARB_IDLE;
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
